axis_dwidth_downsizer: RTL and testbench

Splits each wide AXI4-Stream word of NUM_REG×WIDTH bits into up to NUM_REG narrow WIDTH-bit beats, most-significant lane first. This matches the lane order of the team's upsizer, so an upsizer→downsizer pair round-trips data. A per-lane keep mask lets the last word of a packet carry fewer than NUM_REG valid lanes. The block sits on the return path, between the wide datapath and narrow AXI-stream consumers.

---
 rtl/axis_dwidth_downsizer_if.sv | 52 +++++
 rtl/axis_dwidth_downsizer.sv | 101 ++++++++++
 tb/tb_axis_dwidth_downsizer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_dwidth_downsizer_if.sv
// Bundle of the wide input stream, the narrow output stream and the
// zero-keep error flag for axis_dwidth_downsizer. The slave modport is the
// downsizer's view. The master modport is the view of the surrounding
// logic, which produces wide words and consumes narrow beats.
interface axis_dwidth_downsizer_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 2
) ();

  // wide side: one word of NUM_REG lanes per handshake
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [WIDTH*NUM_REG-1:0] s_axis_tdata;
  logic [NUM_REG-1:0]       s_axis_tkeep;
  logic                     s_axis_tlast;

  // narrow side: one lane per handshake
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic [WIDTH-1:0]         m_axis_tdata;
  logic                     m_axis_tlast;

  // pulses for one cycle when a word with no kept lanes is swallowed
  logic                     err_zero_keep;

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tlast,
    input  m_axis_tready,
    output err_zero_keep
  );

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tlast,
    output m_axis_tready,
    input  err_zero_keep
  );

endinterface

// File: rtl/axis_dwidth_downsizer.sv
// AXI4-Stream width downsizer. Each wide word of NUM_REG lanes is parked in
// a single holding register. Its kept lanes are then replayed as narrow
// beats, highest lane index first, which matches the lane order of the
// upsizer. Lanes whose keep bit is clear are skipped without an idle beat.
// A new word loads on the same edge that hands off the final lane of the
// current word, so a continuously ready consumer sees one beat per cycle.
module axis_dwidth_downsizer #(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  axis_dwidth_downsizer_if.slave axis
);

  typedef enum logic {
    EMPTY,
    SEND
  } state_t;

  state_t                   state;
  logic [WIDTH*NUM_REG-1:0] hold_data;
  logic [NUM_REG-1:0]       rem_keep;
  logic                     hold_last;
  logic                     err_q;

  logic [NUM_REG-1:0]       cur_onehot;
  logic [WIDTH-1:0]         lane_data;
  logic                     final_lane;
  logic                     s_hs;
  logic                     m_hs;
  logic                     zero_keep;

  // Isolate the highest set bit of the remaining mask; that lane goes next
  always_comb begin
    cur_onehot = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      if (rem_keep[k]) begin
        cur_onehot    = '0;
        cur_onehot[k] = 1'b1;
      end
    end
  end

  // Pick the current lane out of the holding register (zero when none left)
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      if (cur_onehot[k]) begin
        lane_data = hold_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // The lane on the bus is the final one once no other remaining bit is set
  assign final_lane = (state == SEND) && ((rem_keep & ~cur_onehot) == '0);

  assign zero_keep  = (axis.s_axis_tkeep == '0);
  assign m_hs       = (state == SEND) && axis.m_axis_tready;

  // Accept a word when empty, or when the final lane leaves on this edge
  assign axis.s_axis_tready = (state == EMPTY) || (final_lane && axis.m_axis_tready);
  assign s_hs               = axis.s_axis_tvalid && axis.s_axis_tready;

  assign axis.m_axis_tvalid = (state == SEND);
  assign axis.m_axis_tdata  = (state == SEND) ? lane_data : '0;
  assign axis.m_axis_tlast  = hold_last && final_lane;
  assign axis.err_zero_keep = err_q;

  // Holding-register FSM: load whole words, retire one lane per beat
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= EMPTY;
      hold_data <= '0;
      rem_keep  <= '0;
      hold_last <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= s_hs && zero_keep;
      if (s_hs) begin
        if (!zero_keep) begin
          hold_data <= axis.s_axis_tdata;
          rem_keep  <= axis.s_axis_tkeep;
          hold_last <= axis.s_axis_tlast;
          state     <= SEND;
        end else begin
          rem_keep  <= '0;
          hold_last <= 1'b0;
          state     <= EMPTY;
        end
      end else if (m_hs) begin
        rem_keep <= rem_keep & ~cur_onehot;
        if (final_lane) begin
          hold_last <= 1'b0;
          state     <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_dwidth_downsizer.sv
// Directed bench for axis_dwidth_downsizer. One instance runs with two lanes
// and a second with four lanes. Both share clock and reset. Inputs change 1 ns
// after a rising edge and outputs are sampled 4 ns after it.
module tb_axis_dwidth_downsizer;

  localparam int WIDTH = 32;

  logic aclk = 1'b0;
  logic areset;
  int   vectors     = 0;
  int   miscompares = 0;

  axis_dwidth_downsizer_if #(.WIDTH(WIDTH), .NUM_REG(2)) bus2 ();
  axis_dwidth_downsizer_if #(.WIDTH(WIDTH), .NUM_REG(4)) bus4 ();

  axis_dwidth_downsizer #(.WIDTH(WIDTH), .NUM_REG(2)) dut2 (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus2)
  );

  axis_dwidth_downsizer #(.WIDTH(WIDTH), .NUM_REG(4)) dut4 (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus4)
  );

  // 10 ns clock
  always #5 aclk = ~aclk;

  // Drive one cycle of inputs on the selected instance and idle the other
  task automatic applyStimulus(input bit sel4, input logic sv, input logic [127:0] data,
                               input logic [3:0] keep, input logic last, input logic mr);
    @(posedge aclk);
    #1;
    if (sel4) begin
      bus4.s_axis_tvalid = sv;
      bus4.s_axis_tdata  = data;
      bus4.s_axis_tkeep  = keep;
      bus4.s_axis_tlast  = last;
      bus4.m_axis_tready = mr;
      bus2.s_axis_tvalid = 1'b0;
      bus2.s_axis_tdata  = '0;
      bus2.s_axis_tkeep  = '0;
      bus2.s_axis_tlast  = 1'b0;
      bus2.m_axis_tready = 1'b1;
    end else begin
      bus2.s_axis_tvalid = sv;
      bus2.s_axis_tdata  = data[63:0];
      bus2.s_axis_tkeep  = keep[1:0];
      bus2.s_axis_tlast  = last;
      bus2.m_axis_tready = mr;
      bus4.s_axis_tvalid = 1'b0;
      bus4.s_axis_tdata  = '0;
      bus4.s_axis_tkeep  = '0;
      bus4.s_axis_tlast  = 1'b0;
      bus4.m_axis_tready = 1'b1;
    end
    #3;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Valid/data/last of the two-lane instance plus its s_axis_tready
  task automatic checkBeat2(input string tag, input logic v, input logic [31:0] d,
                            input logic l, input logic sr);
    checkOutput({tag, ".m_valid"}, 128'(bus2.m_axis_tvalid), 128'(v));
    checkOutput({tag, ".m_data"},  128'(bus2.m_axis_tdata),  128'(d));
    checkOutput({tag, ".m_last"},  128'(bus2.m_axis_tlast),  128'(l));
    checkOutput({tag, ".s_ready"}, 128'(bus2.s_axis_tready), 128'(sr));
  endtask

  task automatic checkBeat4(input string tag, input logic v, input logic [31:0] d,
                            input logic l, input logic sr);
    checkOutput({tag, ".m_valid"}, 128'(bus4.m_axis_tvalid), 128'(v));
    checkOutput({tag, ".m_data"},  128'(bus4.m_axis_tdata),  128'(d));
    checkOutput({tag, ".m_last"},  128'(bus4.m_axis_tlast),  128'(l));
    checkOutput({tag, ".s_ready"}, 128'(bus4.s_axis_tready), 128'(sr));
  endtask

  initial begin
    areset             = 1'b1;
    bus2.s_axis_tvalid = 1'b0;
    bus2.s_axis_tdata  = '0;
    bus2.s_axis_tkeep  = '0;
    bus2.s_axis_tlast  = 1'b0;
    bus2.m_axis_tready = 1'b1;
    bus4.s_axis_tvalid = 1'b0;
    bus4.s_axis_tdata  = '0;
    bus4.s_axis_tkeep  = '0;
    bus4.s_axis_tlast  = 1'b0;
    bus4.m_axis_tready = 1'b1;

    // reset values
    #2;
    checkBeat2("reset2", 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reset2.err", 128'(bus2.err_zero_keep), 128'h0);
    checkBeat4("reset4", 1'b0, 32'h0, 1'b0, 1'b1);
    #5;
    areset = 1'b0;

    // single full word, MS lane first, last only on the second beat
    applyStimulus(0, 1'b1, 128'hAAAA_AAAA_BBBB_BBBB, 4'b0011, 1'b1, 1'b1);
    checkBeat2("w1.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("w1.beat0", 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("w1.beat1", 1'b1, 32'hBBBB_BBBB, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("w1.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // three back-to-back words, s_valid held high
    applyStimulus(0, 1'b1, 128'h0101_0101_0202_0202, 4'b0011, 1'b1, 1'b1);
    checkBeat2("b2b.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 128'h0303_0303_0404_0404, 4'b0011, 1'b1, 1'b1);
    checkBeat2("b2b.beat0", 1'b1, 32'h0101_0101, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 128'h0303_0303_0404_0404, 4'b0011, 1'b1, 1'b1);
    checkBeat2("b2b.beat1", 1'b1, 32'h0202_0202, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 128'h0505_0505_0606_0606, 4'b0011, 1'b1, 1'b1);
    checkBeat2("b2b.beat2", 1'b1, 32'h0303_0303, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 128'h0505_0505_0606_0606, 4'b0011, 1'b1, 1'b1);
    checkBeat2("b2b.beat3", 1'b1, 32'h0404_0404, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("b2b.beat4", 1'b1, 32'h0505_0505, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("b2b.beat5", 1'b1, 32'h0606_0606, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("b2b.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // partial word keep=10, next word loads on its only beat; next tlast=0
    applyStimulus(0, 1'b1, 128'h1111_1111_0000_0000, 4'b0010, 1'b1, 1'b1);
    checkBeat2("part.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 128'h3333_3333_4444_4444, 4'b0011, 1'b0, 1'b1);
    checkBeat2("part.beat", 1'b1, 32'h1111_1111, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("part.next0", 1'b1, 32'h3333_3333, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("part.next1", 1'b1, 32'h4444_4444, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("part.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // backpressure: m_ready 1,0,0,1 across the word
    applyStimulus(0, 1'b1, 128'h5555_5555_6666_6666, 4'b0011, 1'b1, 1'b1);
    checkBeat2("stall.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 128'h7777_0000_7777_0000, 4'b0011, 1'b0, 1'b1);
    checkBeat2("stall.beat0", 1'b1, 32'h5555_5555, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 128'h7777_0000_7777_0000, 4'b0011, 1'b0, 1'b0);
    checkBeat2("stall.hold0", 1'b1, 32'h6666_6666, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 128'h7777_0000_7777_0000, 4'b0011, 1'b0, 1'b0);
    checkBeat2("stall.hold1", 1'b1, 32'h6666_6666, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("stall.release", 1'b1, 32'h6666_6666, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("stall.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // keep=00: no beat, one-cycle error pulse
    applyStimulus(0, 1'b1, 128'h9999_9999_9999_9999, 4'b0000, 1'b1, 1'b1);
    checkOutput("zk.err_before", 128'(bus2.err_zero_keep), 128'h0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkOutput("zk.err_pulse", 128'(bus2.err_zero_keep), 128'h1);
    checkBeat2("zk.nobeat", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkOutput("zk.err_after", 128'(bus2.err_zero_keep), 128'h0);
    checkBeat2("zk.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    // reset after the first beat of a word discards the second lane
    applyStimulus(0, 1'b1, 128'h7777_7777_8888_8888, 4'b0011, 1'b1, 1'b1);
    checkBeat2("rst.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("rst.beat0", 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("rst.beat1_pending", 1'b1, 32'h8888_8888, 1'b1, 1'b1);
    areset = 1'b1;
    #1;
    checkBeat2("rst.during", 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    areset = 1'b0;
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("rst.after0", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat2("rst.after1", 1'b0, 32'h0, 1'b0, 1'b1);

    // four lanes, keep=1010 with lanes 3..0 = 4,3,2,1, tlast=1 then tlast=0
    applyStimulus(1, 1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1010, 1'b1, 1'b1);
    checkBeat4("n4.accept", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat4("n4.beat0", 1'b1, 32'h4, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat4("n4.beat1", 1'b1, 32'h2, 1'b1, 1'b1);
    applyStimulus(1, 1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1010, 1'b0, 1'b1);
    checkBeat4("n4.accept_nl", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat4("n4.nl_beat0", 1'b1, 32'h4, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat4("n4.nl_beat1", 1'b1, 32'h2, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 128'h0, 4'b0000, 1'b0, 1'b1);
    checkBeat4("n4.idle", 1'b0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
